// File: rtl/b1553_host_responder.sv
// ---------------------------------------------------------------------------
// b1553_host_responder
//   Chip-side responder for the 1553B host bus. Decodes CSn/RD_WRn/MEM_REGn/
//   ADDR, serves a 16-bit register file and a shared RAM, and completes every
//   access with RDYn after WAIT_CYCLES extra cycles.
//
// Parameters
//   WAIT_CYCLES     extra cycles between access capture and RDYn fall (0..255)
//   RAM_DEPTH       shared RAM depth in 16-bit words (power of 2, <= 4096)
//
// Ports
//   CLK_16MHz       sole clock, rising edge
//   HRESET          synchronous active-high hard reset
//   B1553_RSTn      synchronous active-low host soft reset
//   B1553_CSn       chip select, active low
//   B1553_RD_WRn    1 = read, 0 = write
//   B1553_MEM_REGn  1 = RAM, 0 = register
//   B1553_ADDR      word address
//   B1553_DATA_IN   host write data
//   B1553_DATA_OUT  read data (held after the access ends)
//   B1553_DATA_OE   responder drives the data bus
//   B1553_RDYn      access complete, active low
//   INT_EVENT       per-bit interrupt event pulses
//   RT_STATE_WORD   live value returned by register 0x0E
//   START_PULSE     one-cycle pulse on a write to register 0x03
//   START_DATA      data of the last 0x03 write
//   IRQn            low while (INT_STATUS & INT_MASK) != 0, registered
// ---------------------------------------------------------------------------
module b1553_host_responder #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned RAM_DEPTH   = 1024
) (
    input  logic        CLK_16MHz,
    input  logic        HRESET,
    input  logic        B1553_RSTn,
    input  logic        B1553_CSn,
    input  logic        B1553_RD_WRn,
    input  logic        B1553_MEM_REGn,
    input  logic [11:0] B1553_ADDR,
    input  logic [15:0] B1553_DATA_IN,
    output logic [15:0] B1553_DATA_OUT,
    output logic        B1553_DATA_OE,
    output logic        B1553_RDYn,
    input  logic [15:0] INT_EVENT,
    input  logic [15:0] RT_STATE_WORD,
    output logic        START_PULSE,
    output logic [15:0] START_DATA,
    output logic        IRQn
);

    localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        rst_any;
    logic        capture;
    logic        done_entry;
    logic        rdy_n;
    logic        oe;

    logic [11:0] addr_q;
    logic        rd_q;
    logic        mem_q;

    logic [15:0] rf_q [16];
    logic [15:0] sp_q;
    logic [15:0] int_status_q;
    logic        irqn_q;
    logic [15:0] data_out_q;
    logic        start_pulse_q;
    logic [15:0] start_data_q;

    logic [15:0] ram_q [RAM_DEPTH];
    logic        ram_hit;
    logic [AW-1:0] ram_idx;
    logic [15:0] ram_rdata;

    logic        reg_mapped;
    logic [15:0] reg_rdata;
    logic        reg_wr;
    logic        start_wr;
    logic        stat_clr;

    // Soft reset behaves like hard reset for everything except START_DATA.
    assign rst_any = HRESET | ~B1553_RSTn;

    function automatic logic is_rw(input logic [3:0] a);
        case (a)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h5,
            4'h7, 4'h8, 4'h9, 4'hA, 4'hD: is_rw = 1'b1;
            default:                     is_rw = 1'b0;
        endcase
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK_16MHz) begin
        if (rst_any) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!B1553_CSn) begin
                    state_d = ACCESS;
                    cnt_d   = 8'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (B1553_CSn) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (B1553_CSn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / strobes ----------------
    // RDYn and OE follow the DONE state directly, so both change on the same
    // edges the state does and need no separate registers.
    always_comb begin
        rdy_n      = 1'b1;
        oe         = 1'b0;
        capture    = (state_q == IDLE)   && (state_d == ACCESS);
        done_entry = (state_q == ACCESS) && (state_d == DONE);
        if (state_q == DONE) begin
            rdy_n = 1'b0;
            oe    = rd_q;
        end
    end

    // ---------------- decode ----------------
    assign reg_mapped = (addr_q[11:4] == 8'h00);
    assign reg_wr     = done_entry && !rd_q && !mem_q && reg_mapped;
    assign start_wr   = reg_wr && (addr_q[3:0] == 4'h3);
    assign stat_clr   = done_entry && rd_q && !mem_q && reg_mapped && (addr_q[3:0] == 4'h6);

    assign ram_hit    = ({1'b0, addr_q} < 13'(RAM_DEPTH));
    assign ram_idx    = addr_q[AW-1:0];
    assign ram_rdata  = ram_hit ? ram_q[ram_idx] : '0;

    always_comb begin
        reg_rdata = '0;
        if (reg_mapped) begin
            case (addr_q[3:0])
                4'h3:    reg_rdata = sp_q;
                4'h6:    reg_rdata = int_status_q;
                4'hE:    reg_rdata = RT_STATE_WORD;
                4'hF:    reg_rdata = '0;
                default: reg_rdata = is_rw(addr_q[3:0]) ? rf_q[addr_q[3:0]] : '0;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge CLK_16MHz) begin
        if (rst_any) begin
            addr_q        <= '0;
            rd_q          <= 1'b0;
            mem_q         <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
            sp_q          <= '0;
            int_status_q  <= '0;
            irqn_q        <= 1'b1;
            data_out_q    <= '0;
            start_pulse_q <= 1'b0;
        end else begin
            if (capture) begin
                addr_q <= B1553_ADDR;
                rd_q   <= B1553_RD_WRn;
                mem_q  <= B1553_MEM_REGn;
            end
            if (reg_wr && is_rw(addr_q[3:0])) begin
                rf_q[addr_q[3:0]] <= B1553_DATA_IN;
            end
            if (start_wr) begin
                sp_q <= sp_q + 16'd1;
            end
            start_pulse_q <= start_wr;
            // Clear-on-read uses the pre-clear value for the read data; an
            // event on the clearing edge survives the clear.
            int_status_q  <= (stat_clr ? '0 : int_status_q) | INT_EVENT;
            irqn_q        <= ~|(int_status_q & rf_q[0]);
            if (done_entry && rd_q) begin
                data_out_q <= mem_q ? ram_rdata : reg_rdata;
            end
        end
    end

    always_ff @(posedge CLK_16MHz) begin
        if (HRESET) begin
            start_data_q <= '0;
        end else if (start_wr && B1553_RSTn) begin
            start_data_q <= B1553_DATA_IN;
        end
    end

    // RAM has no reset so it keeps its contents across both resets.
    always_ff @(posedge CLK_16MHz) begin
        if (done_entry && !rd_q && mem_q && ram_hit && !rst_any) begin
            ram_q[ram_idx] <= B1553_DATA_IN;
        end
    end

    assign B1553_DATA_OUT = data_out_q;
    assign B1553_DATA_OE  = oe;
    assign B1553_RDYn     = rdy_n;
    assign START_PULSE    = start_pulse_q;
    assign START_DATA     = start_data_q;
    assign IRQn           = irqn_q;

endmodule

// File: doc/b1553_host_responder.md
# b1553_host_responder

- Synthesizable responder for the 1553B host bus: the chip side of the bus our AHB bridges drive.
- Decodes CSn/RD_WRn/MEM_REGn/ADDR, serves a 16-bit register file and a shared RAM, and answers every access with RDYn after a programmable wait.
- Used as a drop-in model of the 1553B terminal for bridge bring-up, both in simulation and on FPGA.

## Interface
- WAIT_CYCLES, 3: extra cycles between access capture and RDYn assertion (0..255).
- RAM_DEPTH, 1024: shared RAM depth in 16-bit words (power of 2, ≤4096).
- CLK_16MHz  in  1  sole clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- B1553_RSTn  in  1  host soft reset, active low, synchronous.
- B1553_CSn  in  1  chip select, active low.
- B1553_RD_WRn  in  1  1 = read, 0 = write.
- B1553_MEM_REGn  in  1  1 = RAM, 0 = register.
- B1553_ADDR  in  12  word address.
- B1553_DATA_IN  in  16  data driven by the host during writes.
- B1553_DATA_OUT  out  16  read data.
- B1553_DATA_OE  out  1  1 = responder drives the data bus; tristate is done at the top level.
- B1553_RDYn  out  1  access complete, active low.
- INT_EVENT  in  16  per-bit interrupt event pulses.
- RT_STATE_WORD  in  16  live value returned at register 0x0E.
- START_PULSE  out  1  one-cycle pulse on a write to register 0x03.
- START_DATA  out  16  data of the last 0x03 write, valid with START_PULSE.
- IRQn  out  1  low while (INT_STATUS & INT_MASK) != 0.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE → ACCESS:
  - Taken on an edge that samples CSn = 0.
  - Latches ADDR, RD_WRn and MEM_REGn.
  - Loads the wait counter with WAIT_CYCLES.
- ACCESS:
  - While the counter ≠ 0: decrement.
  - Counter = 0: go to DONE.
  - CSn sampled 1 at any point: abort to IDLE with no side effects.
- Entry edge into DONE:
  - RDYn ← 0.
  - Write: DATA_IN is sampled on this edge and committed.
  - Read: DATA_OUT is loaded and OE ← 1.
- DONE → IDLE:
  - Taken on the edge that samples CSn = 1.
  - RDYn ← 1, OE ← 0. DATA_OUT holds its value.
- Register map (MEM_REGn = 0). Valid only when ADDR[11:4] = 0; all other addresses are unmapped.
  - 0x00 INT_MASK: RW.
  - 0x01, 0x02, 0x04, 0x05, 0x07, 0x08, 0x09, 0x0A, 0x0D: RW storage.
  - 0x03 write: START_PULSE = 1 for one cycle and START_DATA ← DATA_IN. The stack pointer increments by 1 mod 65536.
  - 0x03 read: returns the stack pointer.
  - 0x06 INT_STATUS: RO, clear-on-read.
  - 0x0E: RO, returns RT_STATE_WORD sampled at DONE entry.
  - 0x0F BIT word: RO, constant 0x0000.
  - Writes to RO registers, and all unmapped accesses: writes ignored, reads return 0x0000. RDYn handshake still completes.
- RAM (MEM_REGn = 1):
  - Index = ADDR.
  - ADDR ≥ RAM_DEPTH: read 0x0000, write ignored.
- INT_STATUS:
  - Each bit sets when its INT_EVENT bit is 1, independent of the mask.
  - A read of 0x06 returns the pre-clear value, then clears the bits.
  - A same-cycle event wins: that bit stays 1.

## Timing
- Reset priority: HRESET > B1553_RSTn > bus activity.
- HRESET (synchronous):
  - FSM → IDLE, all registers → 0, stack pointer → 0.
  - Outputs: RDYn = 1, OE = 0, DATA_OUT = 0x0000, IRQn = 1, START_PULSE = 0, START_DATA = 0.
  - RAM contents are not reset.
- B1553_RSTn = 0: same as HRESET except START_DATA holds its value. Applies even mid-access; an in-flight access is dropped and RDYn is never asserted.
- Latency: with CSn first sampled low at edge E0, RDYn falls at E0 + WAIT_CYCLES + 1.
- Read data is valid from RDYn fall until the edge that samples CSn = 1.
- RDYn stays low until the edge that samples CSn high, then rises on that edge. The next IDLE → ACCESS needs a fresh CSn = 0 sample after that.
- IRQn is registered: it updates one cycle after INT_STATUS or INT_MASK changes.
- Inputs are assumed synchronous to CLK_16MHz; there are no internal synchronizers.

## Test plan
- Register RW, WAIT_CYCLES = 3:
  - Stimulus: write 0xA5C3 to 0x01, then read 0x01.
  - Required: read returns 0xA5C3; RDYn falls exactly 4 cycles after CSn is sampled low; OE = 1 only during the read's DONE.
- RAM:
  - Stimulus: write 0x1234 at address 0x3FF, 0xBEEF at 0x000, and 0x5555 at 0x400 (RAM_DEPTH = 1024); read all three.
  - Required: 0x1234, 0xBEEF, 0x0000.
- Start register:
  - Stimulus: write 0x0001 to 0x03 twice.
  - Required: two single-cycle START_PULSEs with START_DATA = 0x0001; a read of 0x03 returns 0x0002.
- Interrupts:
  - Stimulus: set INT_MASK = 0x0004; pulse INT_EVENT = 0x0006.
  - Required: IRQn goes low; a read of 0x06 returns 0x0006; afterwards IRQn = 1.
  - Repeat with an INT_EVENT[1] pulse coincident with the clearing edge: a second read returns 0x0002.
- Abort:
  - Stimulus: CSn rises during ACCESS of a write of 0xFFFF to 0x02.
  - Required: RDYn is never asserted and register 0x02 is unchanged.
- Soft reset:
  - Stimulus: assert B1553_RSTn low in DONE of a read.
  - Required: on the next edge RDYn = 1, OE = 0, registers are 0, and RAM keeps its data.
